transmission_scheduler: RTL and testbench
=========================================

# transmission_scheduler

Round-robin time-division scheduler for the 8-channel select-line transmission datapath. Arbitrates eight level requesters and grants one channel per slot. Drives the datapath's A/B/C select lines with the granted channel index, so the selected source bit appears on the matching output. Sits directly in front of the transmission datapath and is its only driver of A, B and C.

## Interface

Parameters:
- SLOT_CYCLES, default 4: maximum cycles per grant. Legal range 1..16. Held internally as SLOT_CYCLES-1 in a 4-bit down-counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- iReq  input  8  level request per channel; bit n = channel n
- A  output  1  select MSB (index bit 2)
- B  output  1  select bit 1
- C  output  1  select LSB (index bit 0)
- oGrant  output  8  one-hot grant; all zero when idle
- oValid  output  1  a slot is active, so A/B/C are meaningful
- oLast  output  1  combinational; high in the final cycle of the current slot

## Operation

- Registered state:
  - state: IDLE or GRANT
  - cur: 3-bit granted index, drives {A,B,C}
  - cnt: 4-bit slot down-counter
  - ptr: 3-bit last round-robin winner
- Reset values (all outputs registered except oLast):
  - state=IDLE, oGrant=8'h00, {A,B,C}=3'b000, oValid=0, oLast=0
  - cnt=0, ptr=3'd7, so channel 0 wins first
- Arbitration point: any cycle in IDLE, or a GRANT cycle with oLast=1.
  - Winner is the first requesting channel searching ptr+1, ptr+2, … ptr, modulo 8.
  - The current holder is therefore eligible last.
  - On a win: cur←winner, ptr←winner, oGrant←1<<winner, cnt←SLOT_CYCLES-1, state←GRANT, oValid←1.
- IDLE:
  - iReq==0: stay in IDLE.
  - Otherwise arbitrate.
- GRANT:
  - oLast = (cnt==0) | ~iReq[cur].
  - oLast=0: cnt←cnt-1; grant and select held.
  - oLast=1 with any request pending: arbitrate. The next slot starts on the next edge with no gap cycle, including a re-grant to the same channel.
  - oLast=1 with no request pending: state←IDLE, oGrant←0, oValid←0. {A,B,C} hold their last value.
- Requests are never preempted mid-slot. A newly raised iReq only matters at arbitration points.
- A requester deasserting mid-slot ends its slot that cycle (early release).
- iReq changing on the same edge as a slot end is sampled as seen at that edge.

## Timing

- Request to grant: iReq sampled high at edge k in IDLE gives oGrant/oValid/{A,B,C} valid after edge k. Latency is 1 cycle.
- Slot length: exactly SLOT_CYCLES cycles when the holder keeps requesting.
  - Shorter on early release: 1 + the number of cycles the request stayed high after the grant.
- SLOT_CYCLES=1: oLast is high in every GRANT cycle, and arbitration runs every cycle.
- Back-to-back slots: oValid stays high continuously, and oGrant/{A,B,C} change on the boundary edge.
- Reset mid-slot: the next edge forces all reset values regardless of iReq. Arbitration resumes the cycle after rst falls.

## Configuration

- TRANS_SCHED_PRIO0_EN defined:
  - At every arbitration point, channel 0 wins whenever iReq[0]=1, regardless of ptr.
  - ptr is not updated when channel 0 wins.
  - Still no mid-slot preemption.
- TRANS_SCHED_PRIO0_EN undefined: pure round-robin as above. Channel 0 has no special treatment.

## Test plan

All scenarios use SLOT_CYCLES=4 unless noted.

- Reset hold, then iReq=8'h00 for 10 cycles -> oGrant=8'h00, {A,B,C}=000, oValid=0, oLast=0 throughout.
- iReq=8'h01 held -> after 1 cycle, oGrant=8'h01, {A,B,C}=000, oValid=1 continuously. oLast pulses every 4th cycle, with re-grants to channel 0 and no gap.
- iReq=8'h85 held -> grant sequence 0,2,7,0,2,… with each slot 4 cycles. {A,B,C} follows 000,010,111 and oValid never drops.
- Channel 3 granted; iReq drops to 8'h20 two cycles into the slot -> oLast=1 that cycle. Next edge gives oGrant=8'h20, {A,B,C}=101.
- Mid-slot on channel 6, rst=1 for one edge -> all outputs at reset values. With rst=0 and iReq=8'h42, the next grant is channel 1 (ptr reset to 7).
- iReq=8'h03 held:
  - Without TRANS_SCHED_PRIO0_EN -> grants alternate 0,1,0,1.
  - With it -> grants 0,0,0 and channel 1 is never granted.
  - SLOT_CYCLES=1 variant -> arbitration runs every cycle with the same orders.

Source files
------------

// File: rtl/transmission_scheduler.sv
// transmission_scheduler
// Round-robin time-division scheduler for the 8-channel select-line
// transmission datapath. Grants one requesting channel per slot and drives
// the datapath's A/B/C select lines with the granted channel index.
//
// Optional feature macro: TRANS_SCHED_PRIO0_EN
//   defined   : channel 0 wins every arbitration point it requests, without
//               moving the round-robin pointer.
//   undefined : pure round-robin, channel 0 has no special treatment.
module transmission_scheduler #(
    parameter int SLOT_CYCLES = 4   // cycles per grant, legal range 1..16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iReq,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [7:0] oGrant,
    output logic       oValid,
    output logic       oLast
);

    // Slot counter runs from SLOT_CYCLES-1 down to 0
    localparam logic [3:0] CNT_LOAD = 4'(SLOT_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cur;
    logic [2:0] w_cur_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_grant;
    logic [7:0] w_grant_nxt;
    logic       r_valid;
    logic       w_valid_nxt;

    logic       w_found;
    logic [2:0] w_winner;
    logic       w_ptr_upd;
    logic       w_last;

    // Round-robin search starting just after the last winner; the last
    // winner itself is visited last so it can only re-win when alone.
    always_comb begin
        logic [2:0] v_idx;
        v_idx     = '0;
        w_found   = 1'b0;
        w_winner  = r_ptr;
        w_ptr_upd = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            v_idx = r_ptr + 3'(i);
            if (!w_found && iReq[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
`ifdef TRANS_SCHED_PRIO0_EN
        // Channel 0 overrides the rotation and leaves the pointer untouched
        if (iReq[0]) begin
            w_found   = 1'b1;
            w_winner  = 3'd0;
            w_ptr_upd = 1'b0;
        end
`endif
    end

    // Slot ends on counter expiry or when the holder drops its request
    assign w_last = (r_state == S_GRANT) && ((r_cnt == 4'd0) || !iReq[r_cur]);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_cur_nxt   = w_winner;
                    w_cnt_nxt   = CNT_LOAD;
                    w_grant_nxt = 8'b1 << w_winner;
                    w_valid_nxt = 1'b1;
                    if (w_ptr_upd) begin
                        w_ptr_nxt = w_winner;
                    end
                end
            end
            S_GRANT: begin
                if (!w_last) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (w_found) begin
                    // Back-to-back slot, possibly to the same channel
                    w_state_nxt = S_GRANT;
                    w_cur_nxt   = w_winner;
                    w_cnt_nxt   = CNT_LOAD;
                    w_grant_nxt = 8'b1 << w_winner;
                    w_valid_nxt = 1'b1;
                    if (w_ptr_upd) begin
                        w_ptr_nxt = w_winner;
                    end
                end else begin
                    // Select lines keep their last value while idle
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_ptr   <= 3'd7;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign A      = r_cur[2];
    assign B      = r_cur[1];
    assign C      = r_cur[0];
    assign oGrant = r_grant;
    assign oValid = r_valid;
    assign oLast  = w_last;

endmodule

// File: tb/tb_transmission_scheduler.sv
// Self-checking bench for transmission_scheduler: two instances
// (SLOT_CYCLES=4 and SLOT_CYCLES=1) share one request stream and are
// compared every cycle against a slot-level behavioural model.
module tb_transmission_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] iReq;

    logic       a0, b0, c0, v0, l0;
    logic [7:0] g0;
    logic       a1, b1, c1, v1, l1;
    logic [7:0] g1;

    int checks = 0;
    int errors = 0;

    transmission_scheduler #(.SLOT_CYCLES(4)) u0 (
        .clk(clk), .rst(rst), .iReq(iReq),
        .A(a0), .B(b0), .C(c0),
        .oGrant(g0), .oValid(v0), .oLast(l0)
    );

    transmission_scheduler #(.SLOT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .iReq(iReq),
        .A(a1), .B(b1), .C(c1),
        .oGrant(g1), .oValid(v1), .oLast(l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who holds the bus, how many cycles the slot has run, last winner
    typedef struct {
        bit valid;
        int cur;
        int ptr;
        int age;
    } mdl_t;

    mdl_t m[2];
    int   slot_len[2] = '{4, 1};

`ifdef TRANS_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    function automatic mdl_t mreset();
        mdl_t s;
        s.valid = 1'b0;
        s.cur   = 0;
        s.ptr   = 7;
        s.age   = 0;
        return s;
    endfunction

    function automatic int pick(logic [7:0] req, int ptr);
        if (PRIO0 && req[0]) return 0;
        for (int i = 1; i <= 8; i++) begin
            if (req[(ptr + i) % 8]) return (ptr + i) % 8;
        end
        return -1;
    endfunction

    function automatic bit mlast(mdl_t s, logic [7:0] req, int slen);
        return s.valid && ((s.age == slen) || !req[s.cur]);
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic [7:0] req, bit r, int slen);
        mdl_t n;
        int   w;
        if (r) return mreset();
        n = s;
        if (!s.valid || mlast(s, req, slen)) begin
            if (req != 8'h00) begin
                w       = pick(req, s.ptr);
                n.cur   = w;
                if (!(PRIO0 && w == 0)) n.ptr = w;
                n.valid = 1'b1;
                n.age   = 1;
            end else begin
                n.valid = 1'b0;
            end
        end else begin
            n.age = s.age + 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [7:0] g, input logic v,
                       input logic l, input logic [2:0] abc);
        logic [7:0] eg;
        eg = m[k].valid ? (8'h01 << m[k].cur) : 8'h00;
        chk($sformatf("u%0d oGrant", k), {24'h0, g}, {24'h0, eg});
        chk($sformatf("u%0d oValid", k), {31'h0, v}, {31'h0, m[k].valid});
        chk($sformatf("u%0d ABC", k), {29'h0, abc}, 32'(m[k].cur));
        chk($sformatf("u%0d oLast", k), {31'h0, l}, {31'h0, mlast(m[k], iReq, slot_len[k])});
    endtask

    // One clock: apply inputs, advance model on the edge, compare mid-cycle
    task automatic tick(input logic [7:0] req, input logic r);
        iReq = req;
        rst  = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) m[k] = mstep(m[k], req, r, slot_len[k]);
        @(negedge clk);
        cmp(0, g0, v0, l0, {a0, b0, c0});
        cmp(1, g1, v1, l1, {a1, b1, c1});
    endtask

    logic [7:0] exp85_0[4];
    logic [7:0] exp85_1[4];
    logic [7:0] exp03[3];
    logic [7:0] rq;

    initial begin
        m[0] = mreset();
        m[1] = mreset();
        rst  = 1'b1;
        iReq = 8'h00;

        // Reset hold, then idle
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) tick(8'h00, 1'b0);
        chk("idle oGrant", {24'h0, g0}, 32'h00);
        chk("idle ABC", {29'h0, a0, b0, c0}, 32'h0);
        chk("idle oValid", {31'h0, v0}, 32'h0);
        chk("idle oLast", {31'h0, l0}, 32'h0);

        // Single requester on channel 0: one-cycle latency, re-grant w/o gap
        tick(8'h01, 1'b0);
        chk("ch0 first grant", {24'h0, g0}, 32'h01);
        chk("ch0 first valid", {31'h0, v0}, 32'h1);
        for (int i = 2; i <= 12; i++) begin
            tick(8'h01, 1'b0);
            chk("ch0 oLast cadence", {31'h0, l0}, {31'h0, (i % 4) == 0});
            chk("ch0 valid held", {31'h0, v0}, 32'h1);
        end

        // 0x85: rotation 0,2,7,0 (channel 0 every slot with priority)
        tick(8'h00, 1'b1);
        exp85_0 = PRIO0 ? '{8'h01, 8'h01, 8'h01, 8'h01} : '{8'h01, 8'h04, 8'h80, 8'h01};
        exp85_1 = exp85_0;
        for (int i = 1; i <= 16; i++) begin
            tick(8'h85, 1'b0);
            if (i <= 4) chk("sc1 0x85 order", {24'h0, g1}, {24'h0, exp85_1[i-1]});
            if ((i % 4) == 1) chk("sc4 0x85 order", {24'h0, g0}, {24'h0, exp85_0[(i-1)/4]});
            chk("sc4 0x85 valid", {31'h0, v0}, 32'h1);
        end

        // Early release: channel 3 drops two cycles in, channel 5 takes over
        tick(8'h00, 1'b1);
        tick(8'h08, 1'b0);
        chk("ch3 grant", {24'h0, g0}, 32'h08);
        tick(8'h08, 1'b0);
        iReq = 8'h20;
        #1;
        chk("early release oLast", {31'h0, l0}, 32'h1);
        tick(8'h20, 1'b0);
        chk("after release grant", {24'h0, g0}, 32'h20);
        chk("after release ABC", {29'h0, a0, b0, c0}, 32'h5);

        // Reset mid-slot on channel 6, then 0x42 must start at channel 1
        tick(8'h00, 1'b1);
        tick(8'h40, 1'b0);
        tick(8'h40, 1'b0);
        chk("ch6 grant", {24'h0, g0}, 32'h40);
        tick(8'h40, 1'b1);
        chk("mid reset oGrant", {24'h0, g0}, 32'h00);
        chk("mid reset ABC", {29'h0, a0, b0, c0}, 32'h0);
        chk("mid reset oValid", {31'h0, v0}, 32'h0);
        chk("mid reset oLast", {31'h0, l0}, 32'h0);
        tick(8'h42, 1'b0);
        chk("post reset winner", {24'h0, g0}, 32'h02);

        // 0x03: alternate 0,1 (or 0 only with priority)
        tick(8'h00, 1'b1);
        exp03 = PRIO0 ? '{8'h01, 8'h01, 8'h01} : '{8'h01, 8'h02, 8'h01};
        for (int i = 1; i <= 12; i++) begin
            tick(8'h03, 1'b0);
            if (i <= 3) chk("sc1 0x03 order", {24'h0, g1}, {24'h0, exp03[i-1]});
            if ((i % 4) == 1) chk("sc4 0x03 order", {24'h0, g0}, {24'h0, exp03[(i-1)/4]});
        end

        // Randomised traffic with occasional releases, idles and resets
        rq = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0:       rq = 8'h00;
                1, 2:    rq = 8'($urandom);
                3, 4:    rq = rq ^ (8'h01 << $urandom_range(0, 7));
                default: rq = rq;
            endcase
            tick(rq, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
